// File: rtl/interface_controle_drone.sv
// interface_controle_drone: conditions raw left/right/confirm buttons into controle[1:0] and a confirma pulse
//   clock              in   system clock, rising edge
//   reset              in   asynchronous, active-low
//   botao_esquerda     in   raw left button (async, active-high)
//   botao_direita      in   raw right button (async, active-high)
//   botao_confirma     in   raw confirm button (async, active-high)
//   controle           out  2'b10 left, 2'b01 right, 2'b00 none or both
//   confirma           out  one-clock pulse per accepted confirm press
//   db_estado_confirma out  confirm FSM state (debug)
module interface_controle_drone #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_esquerda,
   input  logic       botao_direita,
   input  logic       botao_confirma,
   output logic [1:0] controle,
   output logic       confirma,
   output logic [1:0] db_estado_confirma
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] MAX = '1;
   localparam logic [1:0] SOLTO = 2'b00, PULSO = 2'b01, PRESO = 2'b10;
   logic [2:0] raw, s1, s2;
   logic lvl [3];
   logic [CW-1:0] cnt [3];
   logic [1:0] estado, prox;
   assign raw = {botao_confirma, botao_direita, botao_esquerda};
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   // bit 0 = left, 1 = right, 2 = confirm; the level flips only after DEBOUNCE_CYCLES consecutive differing samples
   for (genvar i = 0; i < 3; i++) begin : g_db
      always_ff @(posedge clock or negedge reset)
         if (!reset) begin
            cnt[i] <= '0;
            lvl[i] <= 1'b0;
         end else if (s2[i] == lvl[i]) cnt[i] <= '0;
         else if (cnt[i] == LAST) begin
            lvl[i] <= ~lvl[i];
            cnt[i] <= '0;
         end else if (cnt[i] != MAX) cnt[i] <= cnt[i] + 1'b1;
   end
   // both-pressed is locked out to 2'b00 so 2'b11 never reaches the simulator
   always_ff @(posedge clock or negedge reset)
      if (!reset) controle <= 2'b00;
      else controle <= (lvl[0] && !lvl[1]) ? 2'b10 : (lvl[1] && !lvl[0]) ? 2'b01 : 2'b00;
   always_comb
      prox = (estado == SOLTO) ? (lvl[2] ? PULSO : SOLTO) :
             (estado == PULSO) ? PRESO :
             (estado == PRESO) ? (lvl[2] ? PRESO : SOLTO) : SOLTO;
   always_ff @(posedge clock or negedge reset)
      if (!reset) estado <= SOLTO;
      else estado <= prox;
   assign confirma = (estado == PULSO);
   assign db_estado_confirma = estado;
endmodule

// File: tb/tb_interface_controle_drone.sv
// tb_interface_controle_drone: randomized and directed checks of interface_controle_drone against a window-based model
module tb_interface_controle_drone;
   localparam int DC = 4;
   logic clock = 1'b0, reset = 1'b0;
   logic botao_esquerda = 1'b0, botao_direita = 1'b0, botao_confirma = 1'b0;
   logic [1:0] controle, db_estado_confirma;
   logic confirma;
   int n_cmp = 0, n_bad = 0;

   interface_controle_drone #(.DEBOUNCE_CYCLES(DC)) dut (
      .clock(clock), .reset(reset),
      .botao_esquerda(botao_esquerda), .botao_direita(botao_direita), .botao_confirma(botao_confirma),
      .controle(controle), .confirma(confirma), .db_estado_confirma(db_estado_confirma)
   );

   always #500 clock = ~clock;

   // model: a button's accepted level flips once its last DC synchronised samples all disagree with it;
   // confirma is the rising edge of the accepted confirm level, one clock later
   logic [2:0] m_s1, m_s2, m_lvl;
   logic [DC-1:0] m_win [3];
   logic [1:0] m_ctl, m_st;
   logic m_conf, m_d1, m_d2;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int b = 0; b < 3; b++) m_win[b] = '0;
      m_ctl = 2'b00; m_st = 2'b00; m_conf = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
   endtask

   task automatic model_edge(input logic [2:0] raw);
      m_ctl = (m_lvl[0] && !m_lvl[1]) ? 2'b10 : (m_lvl[1] && !m_lvl[0]) ? 2'b01 : 2'b00;
      m_d2 = m_d1;
      m_d1 = m_lvl[2];
      m_conf = m_d1 && !m_d2;
      m_st = m_conf ? 2'b01 : m_d1 ? 2'b10 : 2'b00;
      for (int b = 0; b < 3; b++) begin
         m_win[b] = {m_win[b][DC-2:0], m_s2[b]};
         if (m_win[b] == {DC{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   task automatic step(input logic l, input logic r, input logic c);
      botao_esquerda = l; botao_direita = r; botao_confirma = c;
      @(posedge clock);
      if (!reset) model_reset();
      else model_edge({c, r, l});
      #1;
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 1);
      n_cmp++;
      if ({controle, confirma, db_estado_confirma} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_state: got ctl=%b conf=%b st=%b want 00 0 00", controle, confirma, db_estado_confirma);
      end
      reset = 1'b1;
      n = 0;
      do begin
         step(1, 0, 0);
         n++;
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL reset_release: got %b%b%b want %b%b%b", controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end while (controle !== 2'b10 && n < 20);
      n_cmp++;
      if (n != 7) begin
         n_bad++;
         $display("FAIL reset_latency: got %0d clocks want 7", n);
      end
      for (int i = 0; i < 10; i++) step(0, 0, 0);
   endtask

   task automatic test_right_hold();
      int first = -1;
      for (int i = 1; i <= 30; i++) begin
         step(0, i <= 20, 0);
         if (controle === 2'b01 && first < 0) first = i;
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL right_hold@%0d: got %b%b%b want %b%b%b", i, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end
      n_cmp++;
      if (first != 7) begin
         n_bad++;
         $display("FAIL right_first: got clock %0d want 7", first);
      end
      n_cmp++;
      if (controle !== 2'b00) begin
         n_bad++;
         $display("FAIL right_release: got %b want 00", controle);
      end
   endtask

   task automatic test_left_bounce();
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int first = -1;
      for (int i = 1; i <= 16; i++) begin
         step(i <= 4 ? pat[i-1] : 1'b1, 0, 0);
         if (controle === 2'b10 && first < 0) first = i;
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL left_bounce@%0d: got %b%b%b want %b%b%b", i, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end
      n_cmp++;
      if (first != 11) begin
         n_bad++;
         $display("FAIL bounce_first: got clock %0d want 11", first);
      end
      for (int i = 0; i < 10; i++) step(0, 0, 0);
   endtask

   task automatic test_confirm_hold();
      int pulses = 0, at = -1;
      for (int i = 1; i <= 60; i++) begin
         step(0, 0, i <= 50);
         if (confirma === 1'b1) begin
            pulses++;
            at = i;
         end
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL confirm_hold@%0d: got %b%b%b want %b%b%b", i, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end
      n_cmp++;
      if (pulses != 1 || at != 7) begin
         n_bad++;
         $display("FAIL confirm_pulse: got %0d pulses at %0d want 1 at 7", pulses, at);
      end
   endtask

   task automatic test_overlap();
      int pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         step(i <= 25, i >= 3, i >= 12 && i <= 18);
         if (confirma === 1'b1) pulses++;
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL overlap@%0d: got %b%b%b want %b%b%b", i, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end
      n_cmp++;
      if (pulses != 1 || controle !== 2'b01) begin
         n_bad++;
         $display("FAIL overlap_end: got pulses=%0d ctl=%b want 1 01", pulses, controle);
      end
      for (int i = 0; i < 10; i++) step(0, 0, 0);
   endtask

   task automatic test_reset_in_pulse();
      int n = 0, pulses = 0;
      do begin
         step(0, 0, 1);
         n++;
      end while (confirma !== 1'b1 && n < 20);
      n_cmp++;
      if (confirma !== 1'b1) begin
         n_bad++;
         $display("FAIL pulse_reach: got confirma=%b want 1", confirma);
      end
      #200 reset = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({controle, confirma, db_estado_confirma} !== 5'b0) begin
         n_bad++;
         $display("FAIL async_reset: got %b%b%b want 00000", controle, confirma, db_estado_confirma);
      end
      step(0, 0, 1);
      step(0, 0, 1);
      reset = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step(0, 0, 1);
         if (confirma === 1'b1) pulses++;
         n_cmp++;
         if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
            n_bad++;
            $display("FAIL reset_pulse@%0d: got %b%b%b want %b%b%b", i, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
         end
      end
      n_cmp++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL reset_repulse: got %0d pulses want 1", pulses);
      end
      for (int i = 0; i < 10; i++) step(0, 0, 0);
   endtask

   task automatic test_random();
      logic [2:0] v;
      int len;
      for (int s = 0; s < 80; s++) begin
         v = 3'($urandom_range(0, 7));
         len = $urandom_range(1, 9);
         for (int k = 0; k < len; k++) begin
            step(v[0], v[1], v[2]);
            n_cmp++;
            if ({controle, confirma, db_estado_confirma} !== {m_ctl, m_conf, m_st}) begin
               n_bad++;
               $display("FAIL random@%0d: got %b%b%b want %b%b%b", s, controle, confirma, db_estado_confirma, m_ctl, m_conf, m_st);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_right_hold();
      test_left_bounce();
      test_confirm_hold();
      test_overlap();
      test_reset_in_pulse();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
